// File: rtl/rvnoob_pkg.sv
// rvnoob_pkg: shared widths and index/data types for the RVNoob integer register file
package rvnoob_pkg;
  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int REG_IDX_W = $clog2(NREG);
  typedef logic [XLEN-1:0] xlen_t;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;
endpackage

// File: rtl/rvnoob_scoreboard.sv
// rvnoob_scoreboard: per-GPR pending-write busy bits with issue set, write-back clear and flush
module rvnoob_scoreboard
  import rvnoob_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 set_en,
  input  logic [REG_IDX_W-1:0] set_idx,
  input  logic                 clr_en,
  input  logic [REG_IDX_W-1:0] clr_idx,
  input  logic                 flush,
  input  logic [REG_IDX_W-1:0] rd1_idx,
  input  logic [REG_IDX_W-1:0] rd2_idx,
  output logic                 busy1,
  output logic                 busy2
);
  logic [NREG-1:0] busy_q, busy_d;
  for (genvar i = 0; i < NREG; i++) begin : g_busy
    if (i == 0) begin : g_x0
      assign busy_d[i] = 1'b0;
    end else begin : g_xn
      assign busy_d[i] = !flush && ((set_en && set_idx == reg_idx_t'(i)) ||
                                    (busy_q[i] && !(clr_en && clr_idx == reg_idx_t'(i))));
    end
  end
  // busy vector update; a newer producer's set outranks the older producer's clear
  always_ff @(posedge clock) begin
    busy_q <= reset ? '0 : busy_d;
  end
  assign busy1 = busy_q[rd1_idx];
  assign busy2 = busy_q[rd2_idx];
endmodule

// File: rtl/rvnoob_gpr_file.sv
// rvnoob_gpr_file: RV64 32x64 GPR file with RAW scoreboard; RVNOOB_RF_BYPASS_EN enables write-back bypass
module rvnoob_gpr_file
  import rvnoob_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic [REG_IDX_W-1:0] rs1_addr,
  input  logic [REG_IDX_W-1:0] rs2_addr,
  output logic [XLEN-1:0]      rs1_data,
  output logic [XLEN-1:0]      rs2_data,
  input  logic                 iss_valid,
  input  logic [REG_IDX_W-1:0] iss_rd,
  input  logic                 iss_rs1_used,
  input  logic                 iss_rs2_used,
  output logic                 raw_stall,
  input  logic                 wb_en,
  input  logic [REG_IDX_W-1:0] wb_addr,
  input  logic [XLEN-1:0]      wb_data,
  input  logic                 flush,
  output logic [63:0]          wb_count,
  output logic [XLEN-1:0]      rf_0,  rf_1,  rf_2,  rf_3,  rf_4,  rf_5,  rf_6,  rf_7,
  output logic [XLEN-1:0]      rf_8,  rf_9,  rf_10, rf_11, rf_12, rf_13, rf_14, rf_15,
  output logic [XLEN-1:0]      rf_16, rf_17, rf_18, rf_19, rf_20, rf_21, rf_22, rf_23,
  output logic [XLEN-1:0]      rf_24, rf_25, rf_26, rf_27, rf_28, rf_29, rf_30, rf_31
);
  xlen_t       gpr_q [NREG];
  logic [63:0] wb_count_q, wb_count_d;
  logic        wr_en, fwd1, fwd2, busy1, busy2;
  assign wr_en = wb_en && wb_addr != '0;
  assign wb_count_d = wb_count_q + 64'd1;
`ifdef RVNOOB_RF_BYPASS_EN
  assign fwd1 = wr_en && wb_addr == rs1_addr;
  assign fwd2 = wr_en && wb_addr == rs2_addr;
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif
  // storage and retired-write counter; x0 is never written so it stays at its reset zero
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int n = 0; n < NREG; n++) gpr_q[n] <= '0;
      wb_count_q <= '0;
    end else if (wr_en) begin
      gpr_q[wb_addr] <= wb_data;
      wb_count_q <= wb_count_d;
    end
  end
  rvnoob_scoreboard u_sb (
    .clock   (clock),
    .reset   (reset),
    .set_en  (iss_valid && !raw_stall && iss_rd != '0),
    .set_idx (iss_rd),
    .clr_en  (wb_en),
    .clr_idx (wb_addr),
    .flush   (flush),
    .rd1_idx (rs1_addr),
    .rd2_idx (rs2_addr),
    .busy1   (busy1),
    .busy2   (busy2)
  );
  assign raw_stall = (iss_rs1_used && busy1 && !fwd1) || (iss_rs2_used && busy2 && !fwd2);
  assign rs1_data = fwd1 ? wb_data : gpr_q[rs1_addr];
  assign rs2_data = fwd2 ? wb_data : gpr_q[rs2_addr];
  assign wb_count = wb_count_q;
  assign rf_0  = gpr_q[0];  assign rf_1  = gpr_q[1];  assign rf_2  = gpr_q[2];  assign rf_3  = gpr_q[3];
  assign rf_4  = gpr_q[4];  assign rf_5  = gpr_q[5];  assign rf_6  = gpr_q[6];  assign rf_7  = gpr_q[7];
  assign rf_8  = gpr_q[8];  assign rf_9  = gpr_q[9];  assign rf_10 = gpr_q[10]; assign rf_11 = gpr_q[11];
  assign rf_12 = gpr_q[12]; assign rf_13 = gpr_q[13]; assign rf_14 = gpr_q[14]; assign rf_15 = gpr_q[15];
  assign rf_16 = gpr_q[16]; assign rf_17 = gpr_q[17]; assign rf_18 = gpr_q[18]; assign rf_19 = gpr_q[19];
  assign rf_20 = gpr_q[20]; assign rf_21 = gpr_q[21]; assign rf_22 = gpr_q[22]; assign rf_23 = gpr_q[23];
  assign rf_24 = gpr_q[24]; assign rf_25 = gpr_q[25]; assign rf_26 = gpr_q[26]; assign rf_27 = gpr_q[27];
  assign rf_28 = gpr_q[28]; assign rf_29 = gpr_q[29]; assign rf_30 = gpr_q[30]; assign rf_31 = gpr_q[31];
endmodule

// File: tb/tb_rvnoob_gpr_file.sv
// tb_rvnoob_gpr_file: directed self-checking bench for rvnoob_gpr_file
module tb_rvnoob_gpr_file;
  logic        clock, reset;
  logic [4:0]  rs1_addr, rs2_addr, iss_rd, wb_addr;
  logic [63:0] rs1_data, rs2_data, wb_data, wb_count;
  logic        iss_valid, iss_rs1_used, iss_rs2_used, raw_stall, wb_en, flush;
  logic [63:0] rf [32];
  int          checks = 0;
  int          failures = 0;
  rvnoob_gpr_file dut (
    .clock(clock), .reset(reset),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_rs1_used(iss_rs1_used), .iss_rs2_used(iss_rs2_used),
    .raw_stall(raw_stall), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush), .wb_count(wb_count),
    .rf_0(rf[0]),   .rf_1(rf[1]),   .rf_2(rf[2]),   .rf_3(rf[3]),   .rf_4(rf[4]),   .rf_5(rf[5]),
    .rf_6(rf[6]),   .rf_7(rf[7]),   .rf_8(rf[8]),   .rf_9(rf[9]),   .rf_10(rf[10]), .rf_11(rf[11]),
    .rf_12(rf[12]), .rf_13(rf[13]), .rf_14(rf[14]), .rf_15(rf[15]), .rf_16(rf[16]), .rf_17(rf[17]),
    .rf_18(rf[18]), .rf_19(rf[19]), .rf_20(rf[20]), .rf_21(rf[21]), .rf_22(rf[22]), .rf_23(rf[23]),
    .rf_24(rf[24]), .rf_25(rf[25]), .rf_26(rf[26]), .rf_27(rf[27]), .rf_28(rf[28]), .rf_29(rf[29]),
    .rf_30(rf[30]), .rf_31(rf[31])
  );
  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #2;
  endtask
  initial begin
    reset = 1; rs1_addr = 0; rs2_addr = 0; iss_valid = 0; iss_rd = 0; iss_rs1_used = 0;
    iss_rs2_used = 0; wb_en = 0; wb_addr = 0; wb_data = 0; flush = 0;
    tick(); tick();
    rs1_addr = 5; iss_rs1_used = 1;
    #1;
    chk("reset_rf5", rf[5], 64'd0);
    chk("reset_rs1", rs1_data, 64'd0);
    chk("reset_stall", {63'd0, raw_stall}, 64'd0);
    chk("reset_cnt", wb_count, 64'd0);
    reset = 0; iss_rs1_used = 0;
    wb_en = 1; wb_addr = 5; wb_data = 64'hDEAD_BEEF;
    tick();
    wb_en = 0;
    #1;
    chk("wr5_rf5", rf[5], 64'hDEAD_BEEF);
    chk("wr5_rs1", rs1_data, 64'hDEAD_BEEF);
    chk("wr5_cnt", wb_count, 64'd1);
    wb_en = 1; wb_addr = 0; wb_data = 64'hFFFF; rs1_addr = 0; rs2_addr = 0;
    #1;
    chk("x0_rs1_during_wb", rs1_data, 64'd0);
    tick();
    wb_en = 0;
    #1;
    chk("x0_rf0", rf[0], 64'd0);
    chk("x0_rs2", rs2_data, 64'd0);
    chk("x0_cnt", wb_count, 64'd1);
    iss_valid = 1; iss_rd = 0;
    tick();
    iss_valid = 0; iss_rs1_used = 1; rs1_addr = 0;
    #1;
    chk("x0_no_busy", {63'd0, raw_stall}, 64'd0);
    iss_rs1_used = 0; iss_valid = 1; iss_rd = 7;
    tick();
    iss_valid = 0; iss_rs1_used = 1; rs1_addr = 7;
    #1;
    chk("raw7_stall", {63'd0, raw_stall}, 64'd1);
    wb_en = 1; wb_addr = 7; wb_data = 64'h42;
    #1;
`ifdef RVNOOB_RF_BYPASS_EN
    chk("raw7_wb_stall", {63'd0, raw_stall}, 64'd0);
    chk("raw7_wb_rs1", rs1_data, 64'h42);
`else
    chk("raw7_wb_stall", {63'd0, raw_stall}, 64'd1);
    chk("raw7_wb_rs1", rs1_data, 64'd0);
`endif
    tick();
    wb_en = 0;
    #1;
    chk("raw7_after_stall", {63'd0, raw_stall}, 64'd0);
    chk("raw7_after_rs1", rs1_data, 64'h42);
    chk("raw7_cnt", wb_count, 64'd2);
    iss_rs1_used = 0; iss_valid = 1; iss_rd = 9;
    tick();
    wb_en = 1; wb_addr = 9; wb_data = 64'h91;
    tick();
    iss_valid = 0; wb_en = 0; iss_rs1_used = 1; rs1_addr = 9;
    #1;
    chk("set_wins_stall", {63'd0, raw_stall}, 64'd1);
    chk("set_wins_rf9", rf[9], 64'h91);
    iss_valid = 1; iss_rd = 10;
    tick();
    iss_valid = 0;
    #1;
    chk("set_wins_persist", {63'd0, raw_stall}, 64'd1);
    wb_en = 1; wb_addr = 9; wb_data = 64'h92;
    #1;
`ifdef RVNOOB_RF_BYPASS_EN
    chk("wb9_second_stall", {63'd0, raw_stall}, 64'd0);
`else
    chk("wb9_second_stall", {63'd0, raw_stall}, 64'd1);
`endif
    tick();
    wb_en = 0;
    #1;
    chk("wb9_clear_stall", {63'd0, raw_stall}, 64'd0);
    chk("wb9_rf9", rf[9], 64'h92);
    chk("wb9_cnt", wb_count, 64'd4);
    iss_rs1_used = 0; iss_rs2_used = 1; rs2_addr = 10;
    #1;
    chk("stalled_issue_ignored", {63'd0, raw_stall}, 64'd0);
    iss_rs2_used = 0; iss_valid = 1; iss_rd = 3;
    tick();
    iss_rd = 4;
    tick();
    iss_valid = 0; iss_rs2_used = 1; rs2_addr = 4; rs1_addr = 3;
    #1;
    chk("busy4_rs2", {63'd0, raw_stall}, 64'd1);
    iss_rs2_used = 0; iss_rs1_used = 1;
    #1;
    chk("busy3_rs1", {63'd0, raw_stall}, 64'd1);
    iss_rs1_used = 0; flush = 1; iss_valid = 1; iss_rd = 11;
    wb_en = 1; wb_addr = 12; wb_data = 64'h12;
    tick();
    flush = 0; iss_valid = 0; wb_en = 0; iss_rs1_used = 1; iss_rs2_used = 1;
    #1;
    chk("flush_stall_3_4", {63'd0, raw_stall}, 64'd0);
    rs1_addr = 11; iss_rs2_used = 0;
    #1;
    chk("flush_beats_issue", {63'd0, raw_stall}, 64'd0);
    chk("flush_wb_rf12", rf[12], 64'h12);
    chk("flush_keeps_rf5", rf[5], 64'hDEAD_BEEF);
    chk("flush_cnt", wb_count, 64'd5);
    iss_rs1_used = 0; reset = 1; wb_en = 1; wb_addr = 5; wb_data = 64'h55;
    iss_valid = 1; iss_rd = 6;
    tick();
    reset = 0; wb_en = 0; iss_valid = 0; iss_rs1_used = 1; rs1_addr = 6;
    #1;
    chk("rst_mid_rf5", rf[5], 64'd0);
    chk("rst_mid_rf12", rf[12], 64'd0);
    chk("rst_mid_cnt", wb_count, 64'd0);
    chk("rst_mid_stall", {63'd0, raw_stall}, 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
